// File: rtl/des_iter_ctrl_pkg.sv
// DES tables, FSM state encoding and the combinational round function shared by
// the iterative DES controller and its key schedule.
package des_iter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [6:0] IP_TAB [1:64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7};

    localparam logic [6:0] FP_TAB [1:64] = '{
        7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25};

    // Parity bits (8, 16, ..., 64) never appear here, so they drop out of the key.
    localparam logic [6:0] PC1_TAB [1:56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4};

    localparam logic [5:0] PC2_TAB [1:48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

    localparam logic [5:0] E_TAB [1:48] = '{
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
        6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
        6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1};

    localparam logic [5:0] P_TAB [1:32] = '{
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25};

    // One entry per S-box row (box*4 + row); column 0 is the most significant nibble.
    localparam logic [63:0] SBOX [0:31] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    // Bit i set means round i rotates by two positions, otherwise by one.
    localparam logic [1:16] SHIFT_TWO = 16'b0011_1111_0111_1110;

    function automatic logic [1:64] ip_perm(input logic [1:64] x);
        logic [1:64] y;
        y = 64'd0;
        for (int i = 1; i <= 64; i++) y[7'(i)] = x[IP_TAB[7'(i)]];
        return y;
    endfunction

    function automatic logic [1:64] fp_perm(input logic [1:64] x);
        logic [1:64] y;
        y = 64'd0;
        for (int i = 1; i <= 64; i++) y[7'(i)] = x[FP_TAB[7'(i)]];
        return y;
    endfunction

    function automatic logic [1:56] pc1_perm(input logic [1:64] x);
        logic [1:56] y;
        y = 56'd0;
        for (int i = 1; i <= 56; i++) y[6'(i)] = x[PC1_TAB[6'(i)]];
        return y;
    endfunction

    function automatic logic [1:48] pc2_perm(input logic [1:56] x);
        logic [1:48] y;
        y = 48'd0;
        for (int i = 1; i <= 48; i++) y[6'(i)] = x[PC2_TAB[6'(i)]];
        return y;
    endfunction

    // Feistel round function: expansion, key mix, S1-S8 substitution, P permutation.
    function automatic logic [1:32] des_f(input logic [1:32] r, input logic [1:48] k);
        logic [1:48] e;
        logic [1:32] s;
        logic [1:32] p;
        logic [5:0]  six;
        logic [1:0]  row;
        logic [3:0]  col;
        logic [63:0] line;
        e = 48'd0;
        s = 32'd0;
        p = 32'd0;
        for (int i = 1; i <= 48; i++) e[6'(i)] = r[E_TAB[6'(i)]];
        e = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six  = e[6'(6 * b + 1) +: 6];
            row  = {six[5], six[0]};
            col  = six[4:1];
            line = SBOX[5'(4 * b) + {3'd0, row}];
            s[6'(4 * b + 1) +: 4] = 4'(line >> {4'd15 - col, 2'b00});
        end
        for (int i = 1; i <= 32; i++) p[6'(i)] = s[P_TAB[6'(i)]];
        return p;
    endfunction

endpackage

// File: rtl/des_key_sched.sv
// DES key schedule: C/D registers loaded through PC1, rotated per round in the
// direction set by mode, and compressed through PC2 into the round key.
module des_key_sched
    import des_iter_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        mode,
    input  logic [3:0]  cnt,
    input  logic [1:64] key,
    output logic [1:48] k
);

    logic [1:28] c_r;
    logic [1:28] d_r;
    logic [1:28] c_rot_s;
    logic [1:28] d_rot_s;
    logic [1:0]  amt_s;

    // Decrypt walks the schedule backwards and starts unrotated, since a full turn equals K16's position.
    always_comb begin
        amt_s = 2'd0;
        if (mode == 1'b0) begin
            amt_s = SHIFT_TWO[5'({1'b0, cnt}) + 5'd1] ? 2'd2 : 2'd1;
        end else if (cnt == 4'd0) begin
            amt_s = 2'd0;
        end else begin
            amt_s = SHIFT_TWO[5'd17 - 5'({1'b0, cnt})] ? 2'd2 : 2'd1;
        end
    end

    // Rotate C and D independently, modulo 28.
    always_comb begin
        c_rot_s = c_r;
        d_rot_s = d_r;
        case ({mode, amt_s})
            3'b001: begin
                c_rot_s = {c_r[2:28], c_r[1]};
                d_rot_s = {d_r[2:28], d_r[1]};
            end
            3'b010: begin
                c_rot_s = {c_r[3:28], c_r[1:2]};
                d_rot_s = {d_r[3:28], d_r[1:2]};
            end
            3'b101: begin
                c_rot_s = {c_r[28], c_r[1:27]};
                d_rot_s = {d_r[28], d_r[1:27]};
            end
            3'b110: begin
                c_rot_s = {c_r[27:28], c_r[1:26]};
                d_rot_s = {d_r[27:28], d_r[1:26]};
            end
            default: begin
                c_rot_s = c_r;
                d_rot_s = d_r;
            end
        endcase
    end

    assign k = pc2_perm({c_rot_s, d_rot_s});

    // C/D state: PC1 load on accept, rotated value written back each round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_r <= 28'd0;
            d_r <= 28'd0;
        end else if (load) begin
            {c_r, d_r} <= pc1_perm(key);
        end else if (step) begin
            c_r <= c_rot_s;
            d_r <= d_rot_s;
        end
    end

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: one round per clock through a single round function,
// with request/result handshakes and a result register held until consumed.
module des_iter_ctrl
    import des_iter_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [1:64] in_block,
    input  logic [1:64] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] out_block,
    output logic        busy
);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic        mode_r;
    logic [1:32] l_r;
    logic [1:32] r_r;
    logic [1:32] r_nxt_s;
    logic [1:64] out_block_r;
    logic [1:48] k_s;
    logic        load_s;
    logic        step_s;
    logic        last_s;

    des_key_sched u_key_sched (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .step  (step_s),
        .mode  (mode_r),
        .cnt   (cnt_r),
        .key   (in_key),
        .k     (k_s)
    );

    assign last_s  = (cnt_r == 4'd15);
    assign r_nxt_s = l_r ^ des_f(r_r, k_s);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (in_valid)  state_nxt_s = ST_ROUND; else state_nxt_s = ST_IDLE;
            ST_ROUND: if (last_s)    state_nxt_s = ST_DONE;  else state_nxt_s = ST_ROUND;
            ST_DONE:  if (out_ready) state_nxt_s = ST_IDLE;  else state_nxt_s = ST_DONE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode; handshake outputs depend on the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load_s    = 1'b0;
        step_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
                load_s   = in_valid;
            end
            ST_ROUND: begin
                busy   = 1'b1;
                step_s = 1'b1;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: IP load on accept, Feistel update per round, FP of swapped halves at the last round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_r         <= 32'd0;
            r_r         <= 32'd0;
            cnt_r       <= 4'd0;
            mode_r      <= 1'b0;
            out_block_r <= 64'd0;
        end else if (load_s) begin
            {l_r, r_r} <= ip_perm(in_block);
            mode_r     <= in_decrypt;
            cnt_r      <= 4'd0;
        end else if (step_s) begin
            l_r <= r_r;
            r_r <= r_nxt_s;
            if (last_s) begin
                out_block_r <= fp_perm({r_nxt_s, r_r});
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

    assign out_block = out_block_r;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Directed bench for des_iter_ctrl using published DES vectors.
module tb_des_iter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_decrypt;
    logic [1:64] in_block;
    logic [1:64] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [1:64] out_block;
    logic        busy;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_AP = 64'h123556789ABDDEF0;
    localparam logic [63:0] PT_A   = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_A   = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT_B   = 64'h8787878787878787;
    localparam logic [63:0] CT_B   = 64'h0000000000000000;
    localparam logic [63:0] CT_Z   = 64'h8CA64DE9C1B123A7;

    des_iter_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_decrypt (in_decrypt),
        .in_block   (in_block),
        .in_key     (in_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Accept a request at the next rising edge, then scramble the inputs.
    task automatic start_txn(input logic [63:0] key, input logic [63:0] blk, input logic dec);
        @(negedge clk);
        in_key     = key;
        in_block   = blk;
        in_decrypt = dec;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        in_key     = ~key;
        in_block   = ~blk;
        in_decrypt = ~dec;
    endtask

    // Called on the falling edge after the accept; counts rising edges until out_valid.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_txn(input string tag, input logic [63:0] key, input logic [63:0] blk,
                           input logic dec, input logic [63:0] exp);
        int lat;
        start_txn(key, blk, dec);
        wait_out(lat);
        check({tag, " latency"}, 64'(lat), 64'd16);
        check({tag, " block"}, out_block, exp);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " in_ready after"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] held;
        logic        stable_ok;
        logic [63:0] tv_key [3];
        logic [63:0] tv_blk [3];
        logic        tv_dec [3];
        logic [63:0] tv_exp [3];
        int          lat;
        int          w;
        int          acc;
        int          prev_acc;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_decrypt = 1'b0;
        in_block   = 64'd0;
        in_key     = 64'd0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready",  {63'd0, in_ready},  64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset busy",      {63'd0, busy},      64'd0);
        check("reset out_block", out_block,          64'd0);
        rst_n = 1'b1;

        run_txn("enc A", KEY_A, PT_A, 1'b0, CT_A);
        run_txn("dec A", KEY_A, CT_A, 1'b1, PT_A);
        run_txn("enc B", KEY_B, PT_B, 1'b0, CT_B);

        // Backpressure: hold out_ready low with a competing request present.
        start_txn(KEY_A, PT_A, 1'b0);
        wait_out(lat);
        check("hold latency", 64'(lat), 64'd16);
        held       = out_block;
        stable_ok  = 1'b1;
        in_valid   = 1'b1;
        in_key     = KEY_B;
        in_block   = PT_B;
        in_decrypt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || out_block !== held || in_ready || !busy) stable_ok = 1'b0;
        end
        check("hold stable", {63'd0, stable_ok}, 64'd1);
        check("hold block", held, CT_A);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release in_ready",  {63'd0, in_ready},  64'd1);
        check("release busy",      {63'd0, busy},      64'd0);
        check("release out_valid", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;

        // Asynchronous reset while cnt = 7.
        start_txn(KEY_B, PT_B, 1'b0);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset in_ready",  {63'd0, in_ready},  64'd1);
        check("midreset out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset busy",      {63'd0, busy},      64'd0);
        check("midreset out_block", out_block,          64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("post-reset enc B", KEY_B, PT_B, 1'b0, CT_B);

        // Back-to-back with in_valid held high and parity-flipped keys.
        tv_key = '{KEY_AP, KEY_AP, 64'd0};
        tv_blk = '{PT_A, CT_A, 64'd0};
        tv_dec = '{1'b0, 1'b1, 1'b0};
        tv_exp = '{CT_A, PT_A, CT_Z};
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int t = 0; t < 3; t++) begin
            w = 0;
            while (!in_ready && w < 40) begin
                @(negedge clk);
                w++;
            end
            in_key     = tv_key[t];
            in_block   = tv_blk[t];
            in_decrypt = tv_dec[t];
            in_valid   = 1'b1;
            @(posedge clk);
            @(negedge clk);
            acc = cyc;
            if (t > 0) check($sformatf("b2b gap %0d", t), 64'(acc - prev_acc), 64'd18);
            prev_acc = acc;
            wait_out(lat);
            check($sformatf("b2b latency %0d", t), 64'(lat), 64'd16);
            check($sformatf("b2b block %0d", t), out_block, tv_exp[t]);
        end
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/des_iter_ctrl.md
# des_iter_ctrl

Iterative DES engine controller: accepts one 64-bit block plus 64-bit key per transaction and runs the 16 Feistel rounds, one per clock, through a single shared round-function instance (E expansion, S1–S8, P permutation). It owns the L/R state registers, the C/D key-schedule registers, the round counter and the handshake FSM. It sits between the block-level request stream and the result stream, with backpressure on both sides.

## Interface
- No parameters; DES geometry is fixed: 64-bit block, 56 effective key bits, 16 rounds.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  controller can accept a request; high only in IDLE.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled only at accept.
- in_block  in  [1:64]  plaintext or ciphertext; bit 1 is MSB.
- in_key  in  [1:64]  key including parity bits (8, 16, …, 64); parity is ignored.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_block  out  [1:64]  result; stable while out_valid is high.
- busy  out  1  high in ROUND or DONE.

## Operation
- FSM states are IDLE, ROUND and DONE.
- **IDLE:** in_ready=1. When in_valid is high:
  - L,R ← IP(in_block), split into bits 1–32 and 33–64.
  - C,D ← PC1(in_key).
  - mode ← in_decrypt; cnt ← 0; next state ROUND.
- **ROUND, cnt = 0..15:**
  - Encrypt: C,D are rotated left by SHIFT[cnt+1], where SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. K = PC2 of the rotated C,D. The rotated values are written back.
  - Decrypt: the rotation is right by 0 when cnt=0, else by SHIFT[17−cnt]. K = PC2 of the rotated C,D; write back as for encrypt.
  - Round update: L ← R; R ← L ^ f(R, K).
  - At cnt=15: out_block register ← FP(R16 ∥ L16), using the swapped halves. Next state DONE.
  - Otherwise cnt ← cnt+1.
- **DONE:** out_valid=1. When out_ready is high, go to IDLE. No new request is accepted in the same cycle.
- in_valid, in_block, in_key and in_decrypt are ignored outside IDLE. A deasserted or changed in_valid during ROUND has no effect.
- After 16 rounds C,D have completed a full rotation of 28 positions in either mode. They need not be cleared.
- All arithmetic is XOR and bit selection. Rotations are modulo 28 within each of C and D independently.

## Timing
- Reset values:
  - state = IDLE, cnt = 0, L = R = C = D = 0.
  - out_block = 0, out_valid = 0, in_ready = 1, busy = 0.
- Accept at edge E0. Rounds occur at edges E1..E16. out_valid rises after E16.
- Latency from accept to out_valid is 16 cycles.
- Minimum spacing between accepts is 18 cycles, with out_ready held high.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
- out_valid stays high until the out_ready handshake. out_block must not change while out_valid is high.
- rst_n asserted mid-ROUND or in DONE forces IDLE immediately and clears all registers. The in-flight result is lost and no partial out_valid is produced.
- f() is purely combinational and must complete within one cycle.

## Structure
- Shared header des_defs.vh holds:
  - the IP, FP, PC1 and PC2 tables;
  - the SHIFT schedule;
  - the state encodings (IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2).
- Sub-module des_key_sched holds the C/D registers, PC1 load, direction-dependent rotation and PC2. Its inputs are load, step, mode and cnt; its output is K[1:48].
- The existing round function (E, S-boxes, P) is instantiated once, unchanged.
- The controller top contains the FSM, cnt, L/R, IP/FP and the output register.

## Test plan
- Encrypt key 133457799BBCDFF1, block 0123456789ABCDEF → out_block 85E813540F0AB405, with out_valid exactly 16 cycles after accept.
- Decrypt the same key with block 85E813540F0AB405 → out_block 0123456789ABCDEF.
- Encrypt key 0E329232EA6D0D73, block 8787878787878787 → 0000000000000000.
- Hold out_ready=0 for 10 cycles after DONE:
  - out_valid and out_block stay stable.
  - in_ready stays 0 and a second in_valid is ignored.
  - On release, the result is consumed and in_ready returns 1 the next cycle.
- Assert rst_n=0 at cnt=7:
  - All outputs return to reset values asynchronously.
  - After release, a new request produces the correct ciphertext.
- Back-to-back accepts with in_valid held high and out_ready=1: accepts are 18 cycles apart. Alternate encrypt/decrypt; key parity bits flipped give identical results.
